// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;
  localparam logic [31:0] RESET_PC_DEF  = 32'h8000_0000;
  localparam logic [3:0]  INST_MARK_ALL = 4'hF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction memory port: fetch side drives the request, memory returns readData one cycle later.
interface ifu_fetch_if;
  logic [31:0] addr;
  logic        readEn;
  logic        writeEn;
  logic [31:0] writeData;
  logic [3:0]  mark;
  logic [31:0] readData;

  modport master (output addr, readEn, writeEn, writeData, mark, input readData);
  modport slave  (input addr, readEn, writeEn, writeData, mark, output readData);
endinterface

// File: rtl/ifu_fetch_fifo.sv
// Sync FIFO of fetch entries; flush empties it and beats any simultaneous push or pop.
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t din_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t dout_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rptr_q, wptr_q;
  logic [CW-1:0]   count_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= nxt(wptr_q);
      end
      if (pop_i) rptr_q <= nxt(rptr_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, issues single-word reads, buffers responses for decode.
// Optional perf counters enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  ifu_fetch_if.master io_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q;
  logic [CW-1:0] count;
  logic [CW:0]   credit;
  logic          fire, issue, push;
  fetch_entry_t  head, resp;

  assign fire   = out_valid & out_ready;
  // Slots already promised: buffered + in flight, minus the one leaving now.
  assign credit = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, fire};
  assign issue  = reset & ~redirect_valid & (credit < DEPTH_C);

  // Responses land exactly one cycle after issue, so the word arriving in a
  // redirect cycle is the only stale one; the flush discards it in place.
  assign push   = inflight_q & ~redirect_valid;
  assign resp   = '{pc: pc_q - 32'd4, inst: io_inst.readData};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
    else if (issue)     pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
    end
  end

  ifu_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .push_i  (push),
    .din_i   (resp),
    .pop_i   (fire),
    .flush_i (redirect_valid),
    .dout_o  (head),
    .count_o (count)
  );

  assign out_valid         = (count != '0);
  assign out_pc            = head.pc;
  assign out_inst          = head.inst;
  assign io_inst.addr      = pc_q;
  assign io_inst.readEn    = issue;
  assign io_inst.writeEn   = 1'b0;
  assign io_inst.writeData = 32'h0;
  assign io_inst.mark      = INST_MARK_ALL;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push)       perf_fetched_q <= perf_fetched_q + 32'd1;
      if (!out_valid) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: queue-based reference model, directed scenarios plus randomized traffic.
module tb_ifu_fetch;
  import ifu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc, out_inst;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  always #5 clock = ~clock;

  ifu_fetch_if mem_if ();

  ifu_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .io_inst        (mem_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: buffered entries, the pending request and the PC.
  fetch_entry_t mq[$];
  logic [31:0]  m_pc, m_pend_pc, m_fetched, m_stall;
  bit           m_pend;
  bit           mem_req;
  logic [31:0]  mem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_fire();
    return (mq.size() > 0) && out_ready;
  endfunction

  function automatic bit m_issue();
    if (!reset || redirect_valid) return 1'b0;
    return (mq.size() + int'(m_pend) - int'(m_fire())) < 2;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc      = 32'h8000_0000;
    m_pend    = 1'b0;
    m_pend_pc = '0;
    m_fetched = '0;
    m_stall   = '0;
  endtask

  task automatic model_edge();
    bit f, is;
    if (!reset) return;
    f  = m_fire();
    is = m_issue();
    if (mq.size() == 0) m_stall++;
    if (f) void'(mq.pop_front());
    if (redirect_valid) mq.delete();
    else if (m_pend) begin
      mq.push_back(fetch_entry_t'{pc: m_pend_pc, inst: m_pend_pc ^ 32'h1234});
      m_fetched++;
    end
    m_pend    = is;
    m_pend_pc = m_pc;
    if (redirect_valid) m_pc = redirect_pc & ~32'h3;
    else if (is)        m_pc = m_pc + 32'd4;
  endtask

  // Sample and compare on the falling edge.
  task automatic obs();
    @(negedge clock);
    mem_req  = mem_if.readEn;
    mem_addr = mem_if.addr;
    chk("readEn", mem_if.readEn, m_issue());
    chk("addr", mem_if.addr, m_pc);
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_inst", out_inst, mq[0].inst);
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall, m_stall);
`endif
  endtask

  // Advance one edge; memory answers with addr^0x1234, garbage otherwise.
  task automatic adv();
    @(posedge clock);
    model_edge();
    #1;
    mem_if.readData = mem_req ? (mem_addr ^ 32'h1234) : $urandom();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_readEn", mem_if.readEn, 1'b0);
    chk("rst_addr", mem_if.addr, 32'h8000_0000);
    chk("rst_writeEn", mem_if.writeEn, 1'b0);
    chk("rst_writeData", mem_if.writeData, 32'h0);
    chk("rst_mark", mem_if.mark, 32'hF);
    model_reset();
    repeat (2) begin obs(); adv(); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrd;
    mem_if.readData = '0;
    model_reset();
    @(posedge clock); #1;
    do_reset();

    // Streaming from reset
    out_ready = 1'b1; reset = 1'b1;
    obs(); chk("t1_rden0", mem_if.readEn, 1'b1); chk("t1_addr0", mem_if.addr, 32'h8000_0000); adv();
    obs(); chk("t1_valid1", out_valid, 1'b0); adv();
    obs(); chk("t1_valid2", out_valid, 1'b1); chk("t1_pc2", out_pc, 32'h8000_0000);
    chk("t1_inst2", out_inst, 32'h8000_1234); adv();
    for (int i = 0; i < 4; i++) begin
      obs(); chk("t1_stream", out_pc, 32'h8000_0004 + 32'(4 * i)); adv();
    end

    // Backpressure: exactly two issues, order kept on release
    do_reset();
    out_ready = 1'b0; reset = 1'b1; nrd = 0;
    repeat (10) begin obs(); nrd += int'(mem_if.readEn); adv(); end
    chk("t2_issues", nrd, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      obs(); chk("t2_valid", out_valid, 1'b1); chk("t2_pc", out_pc, 32'h8000_0000 + 32'(4 * i)); adv();
    end

    // Redirect with a request in flight
    do_reset();
    out_ready = 1'b1; reset = 1'b1;
    obs(); adv();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
    obs(); chk("t3_noissue", mem_if.readEn, 1'b0); adv();
    redirect_valid = 1'b0;
    obs(); chk("t3_rden", mem_if.readEn, 1'b1); chk("t3_addr", mem_if.addr, 32'h8000_0100);
    chk("t3_v0", out_valid, 1'b0); adv();
    obs(); chk("t3_v1", out_valid, 1'b0); adv();
    obs(); chk("t3_v2", out_valid, 1'b1); chk("t3_pc", out_pc, 32'h8000_0100); adv();

    // Redirect with fire while two entries buffered
    do_reset();
    out_ready = 1'b0; reset = 1'b1;
    repeat (4) begin obs(); adv(); end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    obs(); chk("t4_head", out_pc, 32'h8000_0000); chk("t4_hv", out_valid, 1'b1); adv();
    redirect_valid = 1'b0;
    obs(); chk("t4_flushed", out_valid, 1'b0); chk("t4_addr", mem_if.addr, 32'h8000_0200); adv();
    obs(); chk("t4_v1", out_valid, 1'b0); adv();
    obs(); chk("t4_pc", out_pc, 32'h8000_0200); adv();

    // Reset mid-stream with two buffered
    out_ready = 1'b0;
    repeat (4) begin obs(); adv(); end
    do_reset();
    out_ready = 1'b1; reset = 1'b1;
    obs(); chk("t5_addr", mem_if.addr, 32'h8000_0000); chk("t5_rden", mem_if.readEn, 1'b1); adv();

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    obs(); adv();
    redirect_valid = 1'b0;
    obs(); adv(); obs(); adv();
    obs(); chk("wrap_addr", mem_if.addr, 32'h0); adv();
    obs(); adv();
    obs(); chk("wrap_pc", out_pc, 32'h0); adv();

`ifdef IFU_PERF_CNT_EN
    do_reset();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      out_ready = !(i >= 5 && i < 10);
      obs(); adv();
    end
    obs(); chk("perf_fetched_end", perf_fetched, m_fetched); chk("perf_stall_end", perf_stall, m_stall); adv();
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        reset = 1'b1;
      end
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom();
      obs(); adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
